// File: rtl/jag_mem_pkg.sv
// Shared types and helpers for the Jaguar main-memory to SDRAM channel 1 bridge.
package jag_mem_pkg;

  localparam int unsigned PHRASE_W = 64;
  localparam int unsigned BE_W     = 8;
  localparam int unsigned ADDR_W   = 24;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RDY,
    CAPTURE,
    ACK
  } bridge_state_t;

  // Replace the bytes of old_data selected by be with the matching bytes of new_data.
  function automatic logic [PHRASE_W-1:0] merge_be(
    input logic [PHRASE_W-1:0] old_data,
    input logic [PHRASE_W-1:0] new_data,
    input logic [BE_W-1:0]     be
  );
    logic [PHRASE_W-1:0] res;
    res = old_data;
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (be[i]) res[i*8 +: 8] = new_data[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/jag_phrase_buf.sv
// One-entry phrase buffer: tag/valid/data with lookup, fill, byte-merge and invalidate.
module jag_phrase_buf
  import jag_mem_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   lookup_addr,
  output logic                hit,
  output logic [PHRASE_W-1:0] rd_data,
  input  logic                fill_en,
  input  logic [ADDR_W-1:0]   fill_addr,
  input  logic [PHRASE_W-1:0] fill_data,
  input  logic                merge_en,
  input  logic [ADDR_W-1:0]   merge_addr,
  input  logic [PHRASE_W-1:0] merge_data,
  input  logic [BE_W-1:0]     merge_mask,
  input  logic                inv_en,
  input  logic [ADDR_W-1:0]   inv_addr
);

  logic                valid;
  logic [ADDR_W-1:0]   tag;
  logic [PHRASE_W-1:0] data;

  assign hit     = valid && (tag == lookup_addr);
  assign rd_data = data;

  // Entry update: a fill replaces the entry; invalidate and merge only act on a matching tag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (fill_en) begin
      valid <= 1'b1;
      tag   <= fill_addr;
      data  <= fill_data;
    end else if (inv_en && valid && (tag == inv_addr)) begin
      valid <= 1'b0;
    end else if (merge_en && valid && (tag == merge_addr)) begin
      data  <= merge_be(data, merge_data, merge_mask);
    end
  end

endmodule

// File: rtl/jag_sdram_ch1_bridge.sv
// Adapter from the Jaguar 64-bit phrase bus to SDRAM controller channel 1,
// with a one-phrase read buffer, read-data skew compensation and a watchdog.
module jag_sdram_ch1_bridge
  import jag_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,  // must be >= 2
  parameter int unsigned RD_SKEW  = 1,    // must be >= 1
  parameter bit          CACHE_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req,
  input  logic                cpu_rnw,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [BE_W-1:0]     cpu_be,
  input  logic [PHRASE_W-1:0] cpu_wdata,
  output logic [PHRASE_W-1:0] cpu_rdata,
  output logic                cpu_ack,
  output logic                cpu_err,
  output logic [ADDR_W+1:0]   ch1_addr,
  output logic [PHRASE_W-1:0] ch1_din,
  output logic [BE_W-1:0]     ch1_be,
  output logic                ch1_rnw,
  output logic                ch1_req,
  input  logic [PHRASE_W-1:0] ch1_dout,
  input  logic                ch1_ready
);

  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned SKEW_W = (RD_SKEW < 2) ? 1 : $clog2(RD_SKEW + 1);

  bridge_state_t state, state_next;

  logic [ADDR_W-1:0]   lat_addr;
  logic                lat_rnw;
  logic [BE_W-1:0]     lat_be;
  logic [PHRASE_W-1:0] lat_wdata;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_inc;
  logic [SKEW_W-1:0]   skew_cnt;
  logic                err_flag;
  logic [PHRASE_W-1:0] rdata_q;

  logic                accept;
  logic                buf_hit;
  logic                hit_use;
  logic [PHRASE_W-1:0] buf_data;
  logic                timeout_fire;
  logic                capture_fire;

  assign accept  = (state == IDLE) && cpu_req;
  assign hit_use = CACHE_EN && buf_hit;
  assign cnt_inc = cnt + CNT_W'(1);

  assign ch1_req   = (state == ISSUE);
  assign ch1_addr  = {lat_addr, 2'b00};
  assign ch1_din   = lat_wdata;
  assign ch1_be    = lat_be;
  assign ch1_rnw   = lat_rnw;
  assign cpu_ack   = (state == ACK);
  assign cpu_err   = (state == ACK) && err_flag;
  assign cpu_rdata = rdata_q;

  jag_phrase_buf u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookup_addr (cpu_addr),
    .hit         (buf_hit),
    .rd_data     (buf_data),
    .fill_en     (capture_fire && CACHE_EN),
    .fill_addr   (lat_addr),
    .fill_data   (ch1_dout),
    .merge_en    (accept && !cpu_rnw),
    .merge_addr  (cpu_addr),
    .merge_data  (cpu_wdata),
    .merge_mask  (cpu_be),
    .inv_en      (timeout_fire && !lat_rnw),
    .inv_addr    (lat_addr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode plus the one-cycle timeout and capture strobes.
  always_comb begin
    state_next   = state;
    timeout_fire = 1'b0;
    capture_fire = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_rnw && hit_use)            state_next = ACK;
          else if (!cpu_rnw && cpu_be == '0) state_next = ACK;
          else                               state_next = ISSUE;
        end
      end
      ISSUE:    state_next = WAIT_RDY;
      WAIT_RDY: begin
        // The incremented count is compared so the abort lands TIMEOUT cycles after ISSUE.
        if (ch1_ready) begin
          state_next = lat_rnw ? CAPTURE : ACK;
        end else if (cnt_inc == CNT_W'(TIMEOUT - 1)) begin
          state_next   = ACK;
          timeout_fire = 1'b1;
        end
      end
      CAPTURE: begin
        if (skew_cnt == SKEW_W'(RD_SKEW - 1)) begin
          state_next   = ACK;
          capture_fire = 1'b1;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, watchdog/skew counters and the cpu-side read/error registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_addr  <= '0;
      lat_rnw   <= 1'b0;
      lat_be    <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
      skew_cnt  <= '0;
      err_flag  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (accept) begin
        lat_addr  <= cpu_addr;
        lat_rnw   <= cpu_rnw;
        lat_be    <= cpu_be;
        lat_wdata <= cpu_wdata;
        err_flag  <= 1'b0;
        if (cpu_rnw && hit_use) rdata_q <= buf_data;
      end
      if (state == ISSUE) begin
        cnt      <= '0;
        skew_cnt <= '0;
      end
      if (state == WAIT_RDY && !ch1_ready) cnt <= cnt_inc;
      if (state == CAPTURE) skew_cnt <= skew_cnt + SKEW_W'(1);
      if (capture_fire) rdata_q <= ch1_dout;
      if (timeout_fire) begin
        err_flag <= 1'b1;
        rdata_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_jag_sdram_ch1_bridge.sv
// Directed bench for jag_sdram_ch1_bridge with a transaction-level memory/buffer model.
module tb_jag_sdram_ch1_bridge;

  localparam int TMO  = 8;
  localparam int SKEW = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_rnw;
  logic [23:0] cpu_addr;
  logic [7:0]  cpu_be;
  logic [63:0] cpu_wdata;
  logic [63:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_err;
  logic [25:0] ch1_addr;
  logic [63:0] ch1_din;
  logic [7:0]  ch1_be;
  logic        ch1_rnw;
  logic        ch1_req;
  logic [63:0] ch1_dout;
  logic        ch1_ready;

  jag_sdram_ch1_bridge #(.TIMEOUT(TMO), .RD_SKEW(SKEW), .CACHE_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_rnw   (cpu_rnw),
    .cpu_addr  (cpu_addr),
    .cpu_be    (cpu_be),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_err   (cpu_err),
    .ch1_addr  (ch1_addr),
    .ch1_din   (ch1_din),
    .ch1_be    (ch1_be),
    .ch1_rnw   (ch1_rnw),
    .ch1_req   (ch1_req),
    .ch1_dout  (ch1_dout),
    .ch1_ready (ch1_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Expected bus activity for the transaction in flight.
  int          exp_req_cyc = -1;
  int          exp_ack_cyc = -1;
  logic        exp_err     = 1'b0;
  logic        exp_rd_chk  = 1'b0;
  logic [63:0] exp_rdata   = '0;
  logic [23:0] exp_addr    = '0;
  logic [7:0]  exp_be      = '0;
  logic        exp_rnw     = 1'b0;
  logic [63:0] exp_din     = '0;
  bit          chk_en      = 1'b0;

  logic [63:0] seen_rdata    = '0;
  logic [25:0] seen_req_addr = '0;

  // Behavioural model: SDRAM contents and the one-phrase buffer.
  logic [63:0] mem [logic [23:0]];
  bit          m_valid = 1'b0;
  logic [23:0] m_tag   = '0;
  logic [63:0] m_data  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [23:0] a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  function automatic logic [63:0] apply_be(input logic [63:0] o, input logic [63:0] n,
                                           input logic [7:0] be);
    logic [63:0] mask;
    mask = '0;
    for (int b = 0; b < 8; b++) if (be[b]) mask = mask | (64'hFF << (8 * b));
    return (o & ~mask) | (n & mask);
  endfunction

  // Every-cycle comparison of DUT outputs against the expectation set by the driver.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("cpu_ack", {63'b0, cpu_ack}, {63'b0, cyc == exp_ack_cyc});
      chk("ch1_req", {63'b0, ch1_req}, {63'b0, cyc == exp_req_cyc});
      if (cyc == exp_ack_cyc) begin
        chk("cpu_err", {63'b0, cpu_err}, {63'b0, exp_err});
        if (exp_rd_chk) chk("cpu_rdata", cpu_rdata, exp_rdata);
      end else begin
        chk("cpu_err_idle", {63'b0, cpu_err}, 64'h0);
      end
      if (exp_req_cyc >= 0 && cyc >= exp_req_cyc && cyc < exp_ack_cyc) begin
        chk("ch1_addr", {38'b0, ch1_addr}, {38'b0, exp_addr, 2'b00});
        chk("ch1_be",   {56'b0, ch1_be},   {56'b0, exp_be});
        chk("ch1_rnw",  {63'b0, ch1_rnw},  {63'b0, exp_rnw});
        if (!exp_rnw) chk("ch1_din", ch1_din, exp_din);
      end
      if (cpu_ack) seen_rdata = cpu_rdata;
      if (ch1_req) seen_req_addr = ch1_addr;
    end
  end

  // One bus transaction; d = ready offset from the ISSUE cycle, d < 0 = controller never answers.
  task automatic txn(input bit rnw, input logic [23:0] addr, input logic [7:0] be,
                     input logic [63:0] wdata, input int d);
    int n, r;
    bit hit, nop, sdram, tmo;
    n = cyc;
    cpu_req = 1'b1; cpu_rnw = rnw; cpu_addr = addr; cpu_be = be; cpu_wdata = wdata;
    hit   = rnw && m_valid && (m_tag == addr);
    nop   = !rnw && (be == 8'h00);
    sdram = !hit && !nop;
    tmo   = sdram && (d < 0);
    r     = n + 1 + d;
    if (!rnw && m_valid && m_tag == addr) m_data = apply_be(m_data, wdata, be);
    exp_addr = addr; exp_be = be; exp_rnw = rnw; exp_din = wdata;
    exp_err = tmo; exp_rd_chk = rnw;
    exp_rdata = tmo ? 64'h0 : (hit ? m_data : mem_rd(addr));
    if (sdram) begin
      exp_req_cyc = n + 1;
      exp_ack_cyc = tmo ? n + 1 + TMO : (rnw ? r + SKEW + 1 : r + 1);
    end else begin
      exp_req_cyc = -1;
      exp_ack_cyc = n + 1;
    end
    while (cyc < exp_ack_cyc + 1) begin
      @(posedge clk); #1;
      ch1_ready = sdram && !tmo && (cyc == r);
      ch1_dout  = (sdram && !tmo && rnw && cyc == r + SKEW) ? mem_rd(addr)
                                                            : (64'hDEADBEEF0BADF00D ^ 64'(cyc));
    end
    cpu_req = 1'b0;
    if (sdram && !tmo) begin
      if (rnw) begin m_valid = 1'b1; m_tag = addr; m_data = mem_rd(addr); end
      else     mem[addr] = apply_be(mem_rd(addr), wdata, be);
    end
    if (tmo && !rnw && m_valid && m_tag == addr) m_valid = 1'b0;
  endtask

  task automatic idle(input int n, input bit stray);
    repeat (n) begin
      @(posedge clk); #1;
      ch1_ready = stray;
    end
    ch1_ready = 1'b0;
  endtask

  // Abort a read in WAIT_RDY with reset; no ack may follow and the buffer must be empty.
  task automatic reset_mid(input logic [23:0] addr);
    int n;
    n = cyc;
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = addr; cpu_be = 8'hFF;
    exp_addr = addr; exp_be = 8'hFF; exp_rnw = 1'b1; exp_rd_chk = 1'b1; exp_err = 1'b0;
    exp_req_cyc = n + 1;
    exp_ack_cyc = n + 1000;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0; cpu_req = 1'b0;
    exp_req_cyc = -1; exp_ack_cyc = -1;
    m_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rstmid_ack",   {63'b0, cpu_ack}, 64'h0);
    chk("rstmid_req",   {63'b0, ch1_req}, 64'h0);
    chk("rstmid_addr",  {38'b0, ch1_addr}, 64'h0);
    chk("rstmid_rdata", cpu_rdata, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_rnw = 1'b0; cpu_addr = '0; cpu_be = '0;
    cpu_wdata = '0; ch1_dout = '0; ch1_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_ack",   {63'b0, cpu_ack}, 64'h0);
    chk("rst_cpu_err",   {63'b0, cpu_err}, 64'h0);
    chk("rst_cpu_rdata", cpu_rdata, 64'h0);
    chk("rst_ch1_req",   {63'b0, ch1_req}, 64'h0);
    chk("rst_ch1_addr",  {38'b0, ch1_addr}, 64'h0);
    chk("rst_ch1_din",   ch1_din, 64'h0);
    chk("rst_ch1_be",    {56'b0, ch1_be}, 64'h0);
    chk("rst_ch1_rnw",   {63'b0, ch1_rnw}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; chk_en = 1'b1;
    idle(2, 1'b0);

    mem[24'h000010] = 64'h1122334455667788;
    mem[24'h000020] = 64'hCAFEF00D12345678;

    // Read miss, ready four cycles after ISSUE
    txn(1'b1, 24'h000010, 8'hFF, 64'h0, 4);
    chk("pin_miss_rdata", seen_rdata, 64'h1122334455667788);
    chk("pin_miss_addr",  {38'b0, seen_req_addr}, 64'h40);
    // Read hit
    txn(1'b1, 24'h000010, 8'hFF, 64'h0, 1);
    chk("pin_hit_rdata", seen_rdata, 64'h1122334455667788);
    // Partial write to the buffered phrase, then hit returns merged data
    txn(1'b0, 24'h000010, 8'h0F, 64'hFFFFFFFF_AABBCCDD, 2);
    txn(1'b1, 24'h000010, 8'hFF, 64'h0, 1);
    chk("pin_merge_rdata", seen_rdata, 64'h11223344AABBCCDD);
    // Read timeout, then stray ready pulses while idle
    txn(1'b1, 24'h000020, 8'hFF, 64'h0, -1);
    chk("pin_tmo_rdata", seen_rdata, 64'h0);
    idle(3, 1'b1);
    // Timed-out read must not have filled the buffer
    txn(1'b1, 24'h000020, 8'hFF, 64'h0, 3);
    // Timed-out write to the buffered phrase invalidates it
    txn(1'b0, 24'h000020, 8'hF0, 64'h0123456789ABCDEF, -1);
    txn(1'b1, 24'h000020, 8'hFF, 64'h0, 1);
    chk("pin_inv_rdata", seen_rdata, 64'hCAFEF00D12345678);
    // be = 0 write completes without SDRAM traffic
    txn(1'b0, 24'h000030, 8'h00, 64'hFFFFFFFFFFFFFFFF, 1);
    // Full write miss, then read with ready on the last cycle before the watchdog
    txn(1'b0, 24'h000030, 8'hFF, 64'h5555AAAA5555AAAA, 5);
    txn(1'b1, 24'h000030, 8'hFF, 64'h0, TMO - 1);
    chk("pin_late_rdata", seen_rdata, 64'h5555AAAA5555AAAA);
    // Buffer now holds 0x30; reading 0x10 misses and returns the written-through merge
    txn(1'b1, 24'h000010, 8'hFF, 64'h0, 1);
    chk("pin_wt_rdata", seen_rdata, 64'h11223344AABBCCDD);
    // Reset during WAIT_RDY, then 0x10 must miss again
    reset_mid(24'h000050);
    txn(1'b1, 24'h000010, 8'hFF, 64'h0, 2);
    chk("pin_postrst_addr", {38'b0, seen_req_addr}, 64'h40);
    idle(3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jag_sdram_ch1_bridge.md
Name: jag_sdram_ch1_bridge

Overview:
- Upstream adapter between the Jaguar 64-bit main-memory bus (CPU/OP/blitter phrase accesses) and channel 1 of the SDRAM controller.
- Converts a held-level bus request into a single-cycle ch1_req pulse and waits for the ch1_ready pulse.
- Compensates for the controller's one-cycle skew between ch1_ready and the final ch1_dout word.
- Holds a one-phrase read buffer so back-to-back reads of the same phrase complete without an SDRAM access; adds a watchdog timeout.

Parameters:
- TIMEOUT, 255: WAIT_RDY cycles before the access is aborted with an error.
- RD_SKEW, 1: cycles from ch1_ready to a complete ch1_dout (fixed by the controller's read capture).
- CACHE_EN, 1: 0 disables the phrase buffer; every read then goes to SDRAM.

Ports:
- clk  in  1  system clock, same ~100 MHz clock as the SDRAM controller
- rst_n  in  1  synchronous, active-low reset
- cpu_req  in  1  access request; held high until cpu_ack
- cpu_rnw  in  1  1 = read, 0 = write
- cpu_addr  in  24  phrase address [26:3]
- cpu_be  in  8  byte enables; be[7] = bits 63:56
- cpu_wdata  in  64  write data
- cpu_rdata  out  64  read data, valid when cpu_ack is high
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  high with cpu_ack when the access timed out
- ch1_addr  out  26  to controller, [26:1]; = {cpu_addr, 2'b00}
- ch1_din  out  64  to controller
- ch1_be  out  8  to controller
- ch1_rnw  out  1  to controller
- ch1_req  out  1  one-cycle request pulse
- ch1_dout  in  64  from controller
- ch1_ready  in  1  one-cycle completion pulse from controller

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - state IDLE; all outputs 0, including cpu_rdata, ch1_addr, ch1_din, ch1_be and ch1_rnw.
  - Phrase buffer invalid; timeout counter 0.
- States: IDLE, ISSUE, WAIT_RDY, CAPTURE, ACK.
- IDLE, cpu_req sampled high at cycle N: latch addr, rnw, be and wdata. Then:
  - Read hit (CACHE_EN, buffer valid, tag == addr): go to ACK; cpu_rdata = buffer; cpu_ack at N+1.
  - Write with be == 0: go to ACK; no SDRAM access; cpu_ack at N+1.
  - Otherwise: go to ISSUE.
- ISSUE:
  - ch1_req = 1 for exactly one cycle (N+1); ch1_addr, ch1_din, ch1_be and ch1_rnw are driven from the latch and held stable until ACK.
  - Go to WAIT_RDY; counter cleared.
- WAIT_RDY, ch1_ready = 1:
  - Read: go to CAPTURE.
  - Write: go to ACK.
- WAIT_RDY, no ch1_ready: counter increments. When counter == TIMEOUT-1, go to ACK with cpu_err = 1 and cpu_rdata = 0. A later stray ch1_ready is ignored.
- CAPTURE:
  - Waits RD_SKEW cycles, then samples ch1_dout into cpu_rdata.
  - Fills the buffer: tag = addr, valid = 1. Go to ACK.
- ACK:
  - cpu_ack = 1 for one cycle; cpu_err per the timeout path; go to IDLE.
  - cpu_req is not sampled in the ACK cycle. Earliest next acceptance is the following cycle.
- Latencies from request acceptance:
  - Read miss: cpu_ack = ch1_ready cycle + RD_SKEW + 1.
  - Write: cpu_ack = ch1_ready cycle + 1.
  - Hit: 1 cycle.
- Buffer coherence:
  - A write whose address matches the valid tag merges cpu_wdata into the buffer bytewise per cpu_be, at acceptance.
  - A timed-out write to the cached phrase invalidates the buffer.
  - A timed-out read does not fill the buffer.
- ch1_ready arriving in IDLE, ISSUE or ACK is ignored.
- Bridge never issues a second ch1_req before the previous one completes or times out.
- Reset mid-access: return to IDLE and invalidate the buffer. No cpu_ack is produced for the aborted access.

Decomposition:
- Shared package jag_mem_pkg holds:
  - state enum
  - PHRASE_W = 64, BE_W = 8, ADDR_W = 24
  - byte-merge function merge_be(old, new, be)
- Sub-module jag_phrase_buf: one-entry tag/valid/data register with lookup, fill, byte-merge and invalidate ports.

Test Plan:
- Read miss: addr 0x000010, controller model returns 0x1122334455667788, ready at cycle 5 → one ch1_req pulse; ch1_addr = 0x40; cpu_ack at ready+2 with that data; err = 0.
- Read hit: repeat read of 0x000010 → cpu_ack 1 cycle after acceptance, same data, no ch1_req.
- Write merge: write to 0x000010 with be = 0x0F, wdata = 0xFFFFFFFF_AABBCCDD, then read → ch1_be = 0x0F; cpu_ack at ready+1; read hits, returns 0x11223344AABBCCDD.
- Timeout: TIMEOUT = 8, controller never readies → cpu_ack with cpu_err = 1 and rdata = 0, 8 cycles after ISSUE; a stray ready later is ignored.
- be = 0 write → cpu_ack at N+1, ch1_req stays 0.
- Reset mid-access: rst_n low while in WAIT_RDY, then re-read 0x000010 → no ack for the aborted access; re-read misses (buffer invalid).
